// File: rtl/imuldiv_muldiv_dispatch.sv
// Steers unified mul/div requests to the iterative multiplier or divider and
// returns their responses in request order. IMULDIV_DISPATCH_PERF_EN adds perf counters.
module imuldiv_muldiv_dispatch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [1:0]  muldivreq_msg_fn,
    input  logic [31:0] muldivreq_msg_a,
    input  logic [31:0] muldivreq_msg_b,
    input  logic        muldivreq_val,
    output logic        muldivreq_rdy,

    output logic [63:0] muldivresp_msg_result,
    output logic        muldivresp_val,
    input  logic        muldivresp_rdy,

    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,

    input  logic [63:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,

    output logic        divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,

    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy
`ifdef IMULDIV_DISPATCH_PERF_EN
    ,
    output logic [31:0] perf_mul_cnt,
    output logic [31:0] perf_div_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic             sel;
    logic             head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] sel_fifo;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // 01 DIV and 10 DIVU go to the divider; 00 MUL and reserved 11 to the multiplier.
    assign sel   = (muldivreq_msg_fn == 2'b01) || (muldivreq_msg_fn == 2'b10);
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = sel_fifo[rd_ptr];

    assign muldivreq_rdy = !full && (sel ? divreq_rdy : mulreq_rdy);
    assign mulreq_val    = muldivreq_val && !full && !sel;
    assign divreq_val    = muldivreq_val && !full && sel;

    assign mulreq_msg_a  = muldivreq_msg_a;
    assign mulreq_msg_b  = muldivreq_msg_b;
    assign divreq_msg_a  = muldivreq_msg_a;
    assign divreq_msg_b  = muldivreq_msg_b;
    assign divreq_msg_fn = (muldivreq_msg_fn == 2'b01);

    assign muldivresp_val        = !empty && (head ? divresp_val : mulresp_val);
    assign muldivresp_msg_result = head ? divresp_msg_result : mulresp_msg_result;
    assign mulresp_rdy           = !empty && !head && muldivresp_rdy;
    assign divresp_rdy           = !empty && head && muldivresp_rdy;

    assign push = muldivreq_val && muldivreq_rdy;
    assign pop  = muldivresp_val && muldivresp_rdy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the sel storage is deliberately not reset; an entry is only read
    // while count says it holds a live request, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (push) sel_fifo[wr_ptr] <= sel;
    end

`ifdef IMULDIV_DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_mul_cnt   <= '0;
            perf_div_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && !sel) perf_mul_cnt <= perf_mul_cnt + 32'd1;
            if (push && sel)  perf_div_cnt <= perf_div_cnt + 32'd1;
            if (muldivreq_val && !muldivreq_rdy) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
